prescaled_timer: RTL
====================

// Module: prescaled_timer
//
// PURPOSE
//   Parametrised timer/counter: the general-purpose successor to the plain
//   enable counter. Adds a programmable prescaler, an up/down direction and a
//   programmable period. It also has periodic or one-shot mode, a parallel
//   load, a compare-match output and a wrap pulse.
//   Sits under the peripheral/timer logic. All control inputs come from
//   software-visible registers driven by the bus slave.
//
// PARAMETERS
//   WIDTH      16  width of count value, period, compare and load value
//   PSC_WIDTH   8  width of prescaler divisor and internal prescaler counter
//
// PORTS
//   clk        in   1          system clock, all logic on rising edge
//   reset      in   1          synchronous, active-high reset
//   en         in   1          count enable; low freezes prescaler and value
//   dir_down   in   1          0 = count up, 1 = count down
//   oneshot    in   1          0 = periodic, 1 = stop at first wrap
//   load       in   1          load load_val into val, restart prescaler
//   load_val   in   WIDTH      value written by load
//   period     in   WIDTH      terminal count (up) / reload value (down)
//   prescale   in   PSC_WIDTH  step every prescale+1 enabled cycles
//   cmp        in   WIDTH      compare value
//   val        out  WIDTH      current count (registered)
//   wrap       out  1          one-cycle pulse: a wrap occurred
//   cmp_match  out  1          val == cmp (combinational from val)
//   done       out  1          one-shot finished; holds until load/reset
//
// BEHAVIOUR
//   Reset:
//     - val=0, psc=0, wrap=0, done=0, FSM=RUN.
//     - Reset overrides every other input.
//   Priority: reset > load > step.
//   Prescaler:
//     - Internal counter psc counts only when en=1 and FSM=RUN.
//     - step = en && RUN && (psc == prescale). On step, psc <= 0; otherwise psc++.
//     - prescale=0 gives a step on every enabled cycle.
//   Up mode (dir_down=0), on step:
//     - If val == period or val == all-ones: val <= 0, wrap event.
//     - Otherwise val <= val+1.
//     - A load_val above period therefore runs to all-ones, then wraps to 0.
//   Down mode (dir_down=1), on step:
//     - If val == 0: val <= period, wrap event.
//     - Otherwise val <= val-1.
//   Wrap pulse:
//     - wrap is registered: high for exactly one cycle, the cycle after the
//       step that caused the wrap event.
//   FSM:
//     - RUN -> DONE on a wrap event while oneshot=1.
//     - In the DONE transition val does not reload. It holds its terminal
//       value: period (up) or 0 (down).
//     - wrap still pulses once. done=1 while in DONE.
//     - In DONE, steps are ignored and psc is held at 0.
//     - DONE -> RUN only on load or reset.
//     - Clearing oneshot while in DONE does not restart the counter.
//   Load:
//     - val <= load_val, psc <= 0, FSM <= RUN, done <= 0, wrap <= 0.
//     - A step in the same cycle is discarded; it causes no wrap.
//   Live inputs:
//     - dir_down, period, prescale and cmp are sampled live.
//     - A change applies from the next step or comparison. No flush occurs.
//     - If prescale is lowered below the current psc, psc runs up to
//       all-ones, wraps to 0, then matches normally.
//   Arithmetic:
//     - All counters are unsigned and wrap modulo 2^width. No saturation.
//
// TESTING
//   1. WIDTH=8, prescale=0, period=3, up, periodic, en=1:
//      val 0,1,2,3,0,1..; wrap high only in the cycle after each 3->0.
//   2. prescale=2: val advances every 3rd enabled cycle. Dropping en for
//      5 cycles freezes both val and psc; counting resumes with phase intact.
//   3. down, oneshot, load_val=2, period=9: val 2,1,0 then holds 0, wrap
//      pulses once, done=1. Load 5 -> done=0, val=5, counting resumes.
//   4. load=1 with load_val=7 in the same cycle as a step where val==period:
//      val=7 next cycle, wrap stays 0.
//   5. reset asserted mid-count (prescale=5, val=0x7, psc=3): next cycle
//      val=0, wrap=0, done=0; first step after reset arrives 6 cycles later.
//   6. cmp=4, up, period=10: cmp_match is high exactly in the cycles with
//      val==4. Setting cmp=11 (> period) gives cmp_match that never asserts.

Source files
------------

// File: rtl/prescaled_timer_if.sv
// ---------------------------------------------------------------------------
// prescaled_timer_if
//
// Purpose:
//   Groups the control inputs and status outputs of prescaled_timer into one
//   bundle. clk and reset are not part of the bundle; they stay plain ports
//   on the timer.
//
// Handshake:
//   There is no valid/ready handshake on this interface. Every control is a
//   level taken from a software-visible register and is sampled on each
//   rising clk edge. Every status is a level that can be read at any time,
//   except wrap, which is a one-cycle pulse.
//
// Signals (master = register block, slave = timer):
//   en         m->s  count enable
//   dir_down   m->s  0 = up, 1 = down
//   oneshot    m->s  0 = periodic, 1 = stop at first wrap
//   load       m->s  parallel load strobe
//   load_val   m->s  value written by load
//   period     m->s  terminal count (up) / reload value (down)
//   prescale   m->s  step every prescale+1 enabled cycles
//   cmp        m->s  compare value
//   val        s->m  current count
//   wrap       s->m  one-cycle wrap pulse
//   cmp_match  s->m  val == cmp
//   done       s->m  one-shot finished
//   fsm_dbg    s->m  raw FSM state (0 = RUN, 1 = DONE), for debug
// ---------------------------------------------------------------------------
interface prescaled_timer_if #(
    parameter int WIDTH     = 16,
    parameter int PSC_WIDTH = 8
);
    logic                 en;
    logic                 dir_down;
    logic                 oneshot;
    logic                 load;
    logic [WIDTH-1:0]     load_val;
    logic [WIDTH-1:0]     period;
    logic [PSC_WIDTH-1:0] prescale;
    logic [WIDTH-1:0]     cmp;

    logic [WIDTH-1:0]     val;
    logic                 wrap;
    logic                 cmp_match;
    logic                 done;
    logic                 fsm_dbg;

    modport master (
        output en, dir_down, oneshot, load, load_val, period, prescale, cmp,
        input  val, wrap, cmp_match, done, fsm_dbg
    );

    modport slave (
        input  en, dir_down, oneshot, load, load_val, period, prescale, cmp,
        output val, wrap, cmp_match, done, fsm_dbg
    );
endinterface

// File: rtl/prescaled_timer.sv
// ---------------------------------------------------------------------------
// prescaled_timer
//
// Purpose:
//   General-purpose timer/counter. It has a programmable prescaler, up/down
//   counting, a programmable period, periodic or one-shot operation, a
//   parallel load, a compare-match output and a registered wrap pulse.
//
// Ports:
//   clk    in   system clock, everything on the rising edge
//   reset  in   synchronous, active-high reset
//   bus    slave modport of prescaled_timer_if. It carries en, dir_down,
//          oneshot, load, load_val, period, prescale and cmp in, and val,
//          wrap, cmp_match, done and fsm_dbg out.
//
// Priority of updates: reset > load > prescaled step.
// ---------------------------------------------------------------------------
module prescaled_timer #(
    parameter int WIDTH     = 16,
    parameter int PSC_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    prescaled_timer_if.slave     bus
);

    localparam logic [WIDTH-1:0]     VAL_ZERO = '0;
    localparam logic [WIDTH-1:0]     VAL_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]     VAL_ONES = '1;
    localparam logic [PSC_WIDTH-1:0] PSC_ZERO = '0;
    localparam logic [PSC_WIDTH-1:0] PSC_ONE  = {{(PSC_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e               state_q, state_d;
    logic [WIDTH-1:0]     val_q,   val_d;
    logic [PSC_WIDTH-1:0] psc_q,   psc_d;
    logic                 wrap_q,  wrap_d;

    // Decoded events for the current cycle
    logic                 running;
    logic                 step;
    logic                 up_terminal;
    logic                 down_terminal;
    logic                 wrap_event;

    // -----------------------------------------------------------------------
    // Event decode
    // -----------------------------------------------------------------------
    always_comb begin
        running       = (state_q == ST_RUN);
        // psc is compared with equality, not >=. If prescale is lowered
        // below the current psc, psc keeps counting, wraps through
        // all-ones and then meets prescale again.
        step          = bus.en && running && (psc_q == bus.prescale);
        // Up mode also wraps at all-ones. A value loaded above period then
        // overflows to 0 instead of staying stuck.
        up_terminal   = (val_q == bus.period) || (val_q == VAL_ONES);
        down_terminal = (val_q == VAL_ZERO);
        wrap_event    = step && (bus.dir_down ? down_terminal : up_terminal);
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        psc_d   = psc_q;
        wrap_d  = 1'b0;

        if (bus.load) begin
            // Load wins over a step in the same cycle. The step is dropped
            // and produces no wrap.
            val_d   = bus.load_val;
            psc_d   = PSC_ZERO;
            state_d = ST_RUN;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (bus.en) begin
                        if (step) begin
                            psc_d = PSC_ZERO;
                            if (wrap_event) begin
                                wrap_d = 1'b1;
                                if (bus.oneshot) begin
                                    // Stop on the terminal value. val is
                                    // not written, so it stays at period
                                    // (up) or 0 (down).
                                    state_d = ST_DONE;
                                end else if (bus.dir_down) begin
                                    val_d = bus.period;
                                end else begin
                                    val_d = VAL_ZERO;
                                end
                            end else if (bus.dir_down) begin
                                val_d = val_q - VAL_ONE;
                            end else begin
                                val_d = val_q + VAL_ONE;
                            end
                        end else begin
                            psc_d = psc_q + PSC_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Parked: only load or reset restarts the counter.
                    // Clearing oneshot here has no effect.
                    psc_d = PSC_ZERO;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            val_q   <= VAL_ZERO;
            psc_q   <= PSC_ZERO;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            psc_q   <= psc_d;
            wrap_q  <= wrap_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        bus.val       = val_q;
        bus.wrap      = wrap_q;
        bus.done      = (state_q == ST_DONE);
        bus.cmp_match = (val_q == bus.cmp);
        bus.fsm_dbg   = state_q;
    end

endmodule
